// File: rtl/data_cache.sv
// Two-way set-associative, write-through, no-write-allocate data cache with one-word lines.
// Optional hit/miss counters are enabled by defining DCACHE_STATS_EN.
module data_cache #(
    parameter int ADDRESS_LENGTH = 32,
    parameter int SETS           = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ADDRESS_LENGTH-1:0] a,
    input  logic [ADDRESS_LENGTH-1:0] wd,
    input  logic                      sw,
    input  logic                      sh,
    input  logic                      sb,
    input  logic                      re,
    output logic [ADDRESS_LENGTH-1:0] rd,
    output logic                      stall,
    output logic [ADDRESS_LENGTH-1:0] ram_a,
    output logic [ADDRESS_LENGTH-1:0] ram_wd,
    output logic                      ram_sw,
    output logic                      ram_sh,
    output logic                      ram_sb,
    input  logic [ADDRESS_LENGTH-1:0] ram_rd,
`ifdef DCACHE_STATS_EN
    output logic [31:0]               hit_count,
    output logic [31:0]               miss_count,
`endif
    output logic                      o_dbg_state
);
    localparam int IDX  = $clog2(SETS);
    localparam int TAGW = ADDRESS_LENGTH - IDX - 2;

    typedef enum logic {S_IDLE = 1'b0, S_FILL = 1'b1} state_t;

    state_t                    r_state;
    logic [SETS-1:0]           r_valid [2];
    logic [SETS-1:0]           r_lru;
    logic [TAGW-1:0]           r_tag   [2][SETS];
    logic [ADDRESS_LENGTH-1:0] r_data  [2][SETS];

    logic [IDX-1:0]            w_idx;
    logic [TAGW-1:0]           w_tag;
    logic                      w_store, w_load, w_idle, w_fill;
    logic                      w_hit0, w_hit1, w_hit, w_hit_way;
    logic                      w_load_hit, w_miss, w_store_hit, w_victim;
    logic [ADDRESS_LENGTH-1:0] w_line, w_wd_lane, w_merged;
    logic [3:0]                w_mask_base, w_mask;

    assign w_idx   = a[IDX+1:2];
    assign w_tag   = a[ADDRESS_LENGTH-1:IDX+2];
    assign w_store = sw | sh | sb;
    assign w_load  = re & ~w_store;
    assign w_idle  = (r_state == S_IDLE);
    assign w_fill  = (r_state == S_FILL);

    assign w_hit0     = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_hit1     = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit      = w_hit0 | w_hit1;
    assign w_hit_way  = ~w_hit0;
    assign w_line     = r_data[w_hit_way][w_idx];
    assign w_load_hit = w_idle & w_load & w_hit;
    assign w_miss     = w_idle & w_load & ~w_hit;
    assign w_store_hit = w_idle & w_store & w_hit;

    // Fill target: first empty way (way0 first), otherwise the least-recently-used one.
    assign w_victim = ~r_valid[0][w_idx] ? 1'b0 :
                      ~r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];

    // Store data is lane-aligned the same way the data RAM places it.
    assign w_mask_base = sw ? 4'hF : (sh ? 4'h3 : 4'h1);
    assign w_mask      = w_mask_base << a[1:0];
    assign w_wd_lane   = wd << {a[1:0], 3'b000};

    always_comb begin
        w_merged = w_line;
        for (int i = 0; i < 4; i++) begin
            if (w_mask[i]) w_merged[8*i +: 8] = w_wd_lane[8*i +: 8];
        end
    end

    assign rd     = (w_load_hit & ~rst) ? (w_line >> {a[1:0], 3'b000}) : '0;
    assign stall  = ~rst & (w_miss | w_fill);
    assign ram_a  = w_fill ? {a[ADDRESS_LENGTH-1:2], 2'b00} : a;
    assign ram_wd = wd;
    assign ram_sw = ~rst & w_idle & sw;
    assign ram_sh = ~rst & w_idle & sh;
    assign ram_sb = ~rst & w_idle & sb;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid[0] <= '0;
            r_valid[1] <= '0;
            r_lru      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_miss) begin
                        r_state <= S_FILL;
                    end else if (w_load_hit) begin
                        r_lru[w_idx] <= ~w_hit_way;
                    end
                end
                S_FILL: begin
                    r_valid[w_victim][w_idx] <= 1'b1;
                    r_lru[w_idx]             <= ~w_victim;
                    r_state                  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/data arrays carry no reset; validity alone decides whether they are meaningful.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_tag[w_victim][w_idx]  <= w_tag;
            r_data[w_victim][w_idx] <= ram_rd;
        end else if (w_store_hit) begin
            r_data[w_hit_way][w_idx] <= w_merged;
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (w_load_hit) hit_count  <= hit_count + 32'd1;
            if (w_miss)     miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a small byte-addressed RAM model, load/store drivers,
// and a monitor that checks load data and RAM store traffic against expected queues.
module tb_data_cache;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, wd, rd, ram_a, ram_wd, ram_rd;
    logic        sw, sh, sb, re, stall, ram_sw, ram_sh, ram_sb, dbg_state;
`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    logic [31:0] exp_q[$];
    logic [66:0] st_q[$];
    logic [31:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    data_cache #(.ADDRESS_LENGTH(32), .SETS(8)) dut (
        .clk(clk), .rst(rst), .a(a), .wd(wd), .sw(sw), .sh(sh), .sb(sb), .re(re),
        .rd(rd), .stall(stall), .ram_a(ram_a), .ram_wd(ram_wd),
        .ram_sw(ram_sw), .ram_sh(ram_sh), .ram_sb(ram_sb), .ram_rd(ram_rd),
`ifdef DCACHE_STATS_EN
        .hit_count(hit_count), .miss_count(miss_count),
`endif
        .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign ram_rd = mem[ram_a[11:2]];

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[0]   = 32'hDEADBEEF;
        mem[8]   = 32'h11112222;
        mem[16]  = 32'h33334444;
        mem[128] = 32'hCAFEF00D;
        forever begin
            @(posedge clk);
            if (ram_sw) mem[ram_a[11:2]] <= ram_wd;
            else if (ram_sh) mem[ram_a[11:2]][16*ram_a[1] +: 16] <= ram_wd[15:0];
            else if (ram_sb) mem[ram_a[11:2]][8*ram_a[1:0] +: 8] <= ram_wd[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (re && !(sw | sh | sb) && !stall) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got %h, required no load response", rd);
                end else begin
                    check("rd", rd, exp_q.pop_front());
                end
            end
            if (sw | sh | sb) begin
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL store_unexpected: got ram_a %h, required no store", ram_a);
                end else begin
                    logic [66:0] e;
                    e = st_q.pop_front();
                    check("ram_a", ram_a, e[66:35]);
                    check("ram_wd", ram_wd, e[34:3]);
                    check("ram_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, {29'd0, e[2:0]});
                end
            end
        end
    end

    task automatic do_load(input logic [31:0] addr, input logic [31:0] exp, input int exp_stalls);
        int n;
        n = 0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        a = addr; re = 1'b1;
        forever begin
            @(negedge clk);
            if (!stall) break;
            check("stall_rd", rd, 32'h0);
            if (n == 1) check("fill_ram_a", ram_a, {addr[31:2], 2'b00});
            n++;
            if (n > 6) break;
        end
        check("stall_cycles", 32'(n), 32'(exp_stalls));
        @(posedge clk); #1;
        re = 1'b0;
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] data, input logic [2:0] s);
        st_q.push_back({addr, data, s});
        @(posedge clk); #1;
        a = addr; wd = data; {sw, sh, sb} = s;
        @(negedge clk);
        check("store_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        {sw, sh, sb} = 3'b000;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; a = '0; wd = '0; sw = 0; sh = 0; sb = 0; re = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_stall", {31'd0, stall}, 32'd0);
        check("reset_rd", rd, 32'd0);
        check("reset_strobes", {29'd0, ram_sw, ram_sh, ram_sb}, 32'd0);
        check("reset_state", {31'd0, dbg_state}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Cold miss, then a hit.
        do_load(32'h0001_0000, 32'hDEADBEEF, 2);
`ifdef DCACHE_STATS_EN
        check("hit_count", hit_count, 32'd1);
        check("miss_count", miss_count, 32'd1);
`endif
        do_load(32'h0001_0000, 32'hDEADBEEF, 0);

        // Byte store hit merges into the cached line.
        do_store(32'h0001_0001, 32'h0000_00AA, 3'b001);
        do_load(32'h0001_0000, 32'hDEADAAEF, 0);

        // Three lines into set 0: 0x10000 is evicted as LRU.
        do_load(32'h0001_0020, 32'h11112222, 2);
        do_load(32'h0001_0040, 32'h33334444, 2);
        do_load(32'h0001_0043, 32'h0000_0033, 0);
        do_load(32'h0001_0020, 32'h11112222, 0);
        do_load(32'h0001_0000, 32'hDEADAAEF, 2);
        do_load(32'h0001_0020, 32'h11112222, 0);

        // Halfword store hit at the upper half.
        do_store(32'h0001_0022, 32'h0000_5555, 3'b010);
        do_load(32'h0001_0020, 32'h55552222, 0);
        do_load(32'h0001_0022, 32'h0000_5555, 0);

        // Word store miss does not allocate; a later word store hit updates the line.
        do_store(32'h0001_0100, 32'h12345678, 3'b100);
        do_load(32'h0001_0100, 32'h12345678, 2);
        do_store(32'h0001_0100, 32'hA5A5A5A5, 3'b100);
        do_load(32'h0001_0100, 32'hA5A5A5A5, 0);

        // Reset in the middle of a fill.
        @(posedge clk); #1;
        a = 32'h0001_0200; re = 1'b1;
        @(negedge clk);
        check("detect_stall", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        check("fill_stall", {31'd0, stall}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_fill_stall", {31'd0, stall}, 32'd0);
        check("rst_fill_state", {31'd0, dbg_state}, 32'd0);
        @(posedge clk); #1;
        re = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;

        do_load(32'h0001_0200, 32'hCAFEF00D, 2);
        do_load(32'h0001_0100, 32'hA5A5A5A5, 2);
        do_load(32'h0001_0202, 32'h0000_CAFE, 0);
        do_load(32'h0001_0042, 32'h0000_3333, 2);

        repeat (2) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        check("st_q_drained", 32'(st_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_cache.md
# data_cache

Two-way set-associative, write-through, no-write-allocate data cache between the CPU memory stage and the byte-addressed data RAM. Load misses stall the pipeline while a word-aligned line is fetched from RAM. Stores pass straight through to RAM and update any cached copy. The RAM-side port mirrors the data RAM's signals (byte address, write data, sw/sh/sb strobes, combinational 32-bit read).

## Interface
- ADDRESS_LENGTH, 32, address and data width
- SETS, 8, number of sets; power of two ≥ 2; IDX = log2(SETS)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  32  CPU byte address
- wd  in  32  CPU store data
- sw / sh / sb  in  1 each  CPU store strobes (mutually exclusive)
- re  in  1  CPU load request
- rd  out  32  load data
- stall  out  1  pipeline stall request
- ram_a  out  32  RAM byte address
- ram_wd  out  32  RAM write data
- ram_sw / ram_sh / ram_sb  out  1 each  RAM store strobes
- ram_rd  in  32  RAM combinational read data

## Operation
- One line = one 32-bit word. Index = a[IDX+1:2]; tag = a[31:IDX+2]. Each way holds valid, tag and data. Each set holds one LRU bit naming the least-recently-used way.
- FSM states: IDLE and FILL.
- IDLE, load (re=1, no store strobe):
  - Hit in either way: rd = line >> (8·a[1:0]), zero-filled; stall=0; LRU set to the other way.
  - Miss: stall=1; next state FILL.
- FILL:
  - stall=1; ram_a = {a[31:2],2'b00}; all ram strobes 0.
  - At the clock edge, ram_rd is written into the victim way, with valid=1 and tag set. Victim = first invalid way (way0 preferred), else the LRU way. LRU then names the other way.
  - Next state IDLE. The held request hits on the following cycle.
- IDLE, store (any of sw/sh/sb):
  - ram_a=a, ram_wd=wd, ram_s* = s*, all in the same cycle; stall=0.
  - On a hit, the matching line is byte-merged at the clock edge: sb writes byte a[1:0]; sh writes bytes a[1:0] and a[1:0]+1; sw writes the whole word. LRU is unchanged.
  - On a miss, nothing is allocated.
- When no store is in progress (including during FILL), ram_a defaults to a, ram_wd to wd, and strobes to 0.
- A store strobe has priority over re; re is ignored while any strobe is set.
- rd = 0 unless the current cycle is an IDLE load hit.
- Natural alignment is required. Accesses crossing a word boundary (lh at offset 3, lw at offset ≠0) are unsupported; cache contents after such an access are undefined.

## Timing
- Reset values: all valid=0, all LRU=0, state=IDLE, stall=0, rd=0, ram strobes 0, counters 0.
- Load hit: 0 cycles; rd is combinational from a.
- Load miss: stall is high for exactly 2 cycles (detect, FILL); data is valid on the 3rd cycle.
- Store: 0 cycles; the RAM write and the cache merge occur on the same edge.
- The CPU holds a, re, wd and the strobes stable while stall=1.
- rst asserted during FILL: returns to IDLE immediately; no line is written; stall drops asynchronously.
- A store to an address whose fill is in progress cannot occur, because the CPU is stalled.

## Configuration
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_count [31:0] and miss_count [31:0].
  - hit_count increments on each IDLE load hit.
  - miss_count increments once per miss, in the detect cycle.
  - Both wrap modulo 2^32 and reset to 0.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

## Test plan
- Reset, then load from 0x10000 with RAM word 0xDEADBEEF: stall high for 2 cycles, then rd=0xDEADBEEF with stall=0. A repeated load hits with 0 stalls.
- Cached 0x10000, then sb wd=0x000000AA at 0x10001: ram_sb=1, ram_a=0x10001 in the same cycle. A following load of 0x10000 hits with rd=0xDEADAAEF.
- SETS=8: load 0x10000, then 0x10020, then 0x10040 (same set). The third load evicts 0x10000 (LRU). Loading 0x10020 hits; loading 0x10000 misses.
- Store sw 0x12345678 to uncached 0x10100: RAM is written and no allocation occurs. The next load of 0x10100 misses, then returns 0x12345678.
- Assert rst mid-FILL: stall drops, all lines are invalid. A reload of the same address takes the full 2-cycle miss.
- With DCACHE_STATS_EN, run the first scenario: hit_count=1, miss_count=1.
